// File: rtl/axi_read_slave_if.sv
// AXI read-channel bundle (AR and R) shared by axi_read_slave and its master.
// The signal names match the AXI names used in the rest of the system.
interface axi_read_slave_if;
   logic [31:0] ARADDR;
   logic [3:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic        ARVALID;
   logic        ARREADY;
   logic        RVALID;
   logic        RLAST;
   logic [1:0]  RRESP;
   logic [31:0] RDATA;
   logic        RREADY;

   modport slave (
      input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
      output ARREADY, RVALID, RLAST, RRESP, RDATA
   );

   modport master (
      output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
      input  ARREADY, RVALID, RLAST, RRESP, RDATA
   );
endinterface

// File: rtl/axi_read_slave.sv
// AXI read-only slave backed by a word memory with a backdoor preload port.
// It accepts one burst at a time and returns ARLEN+1 beats: data, or an error response.
module axi_read_slave #(
   parameter int DEPTH = 64
) (
   input  logic                     G_clk,
   input  logic                     G_reset,
   input  logic [31:0]              slave_addr1,
   input  logic [31:0]              slave_addr2,
   axi_read_slave_if.slave          bus,
   input  logic                     mem_we,
   input  logic [$clog2(DEPTH)-1:0] mem_waddr,
   input  logic [31:0]              mem_wdata
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t      state_r, state_s;
   logic [31:0] addr_r, addr_s;
   logic [3:0]  len_r, len_s;
   logic [2:0]  size_r, size_s;
   logic [1:0]  burst_r, burst_s;
   logic [3:0]  beat_r, beat_s;
   logic        arready_r, arready_s;
   logic        rvalid_r, rvalid_s;
   logic        rlast_r, rlast_s;
   logic [1:0]  rresp_r, rresp_s;
   logic [31:0] rdata_r, rdata_s;

   logic [31:0] mem_r [DEPTH];

   logic [1:0]    acc_resp_s;
   logic [31:0]   addr_adv_s;
   logic [AW-1:0] acc_idx_s;
   logic [AW-1:0] adv_idx_s;

   function automatic logic [AW-1:0] word_index(input logic [31:0] addr,
                                                input logic [31:0] base);
      return AW'((addr - base) >> 2);
   endfunction

   // Out-of-range wins over every other error; protocol errors only matter in range.
   function automatic logic [1:0] decode_resp(input logic [31:0] addr,
                                              input logic [3:0]  len,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
      logic [1:0] resp;
      logic       wrap_len_ok;
      wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
      if ((addr < lo) || (addr > hi)) begin
         resp = RESP_DECERR;
      end else if ((size > 3'd2) || (burst == 2'b11) ||
                   ((burst == BURST_WRAP) && !wrap_len_ok)) begin
         resp = RESP_SLVERR;
      end else begin
         resp = RESP_OKAY;
      end
      return resp;
   endfunction

   function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                             input logic [3:0]  len,
                                             input logic [2:0]  size,
                                             input logic [1:0]  burst);
      logic [31:0] step;
      logic [31:0] mask;
      logic [31:0] nxt;
      step = 32'd1 << size;
      mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
      case (burst)
         BURST_FIXED: nxt = addr;
         BURST_INCR:  nxt = addr + step;
         BURST_WRAP:  nxt = (addr & ~mask) | ((addr + step) & mask);
         default:     nxt = addr;
      endcase
      return nxt;
   endfunction

   assign acc_resp_s = decode_resp(bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST,
                                   slave_addr1, slave_addr2);
   assign addr_adv_s = next_addr(addr_r, len_r, size_r, burst_r);
   assign acc_idx_s  = word_index(bus.ARADDR, slave_addr1);
   assign adv_idx_s  = word_index(addr_adv_s, slave_addr1);

   // Next state and next register values; beat data is fetched at the edge that loads it.
   always_comb begin
      state_s   = state_r;
      addr_s    = addr_r;
      len_s     = len_r;
      size_s    = size_r;
      burst_s   = burst_r;
      beat_s    = beat_r;
      arready_s = arready_r;
      rvalid_s  = rvalid_r;
      rlast_s   = rlast_r;
      rresp_s   = rresp_r;
      rdata_s   = rdata_r;
      case (state_r)
         IDLE: begin
            if (bus.ARVALID && arready_r) begin
               state_s   = BURST;
               addr_s    = bus.ARADDR;
               len_s     = bus.ARLEN;
               size_s    = bus.ARSIZE;
               burst_s   = bus.ARBURST;
               beat_s    = 4'd0;
               arready_s = 1'b0;
               rvalid_s  = 1'b1;
               rlast_s   = (bus.ARLEN == 4'd0);
               rresp_s   = acc_resp_s;
               rdata_s   = (acc_resp_s == RESP_OKAY) ? mem_r[acc_idx_s] : 32'd0;
            end else begin
               state_s   = IDLE;
               arready_s = 1'b1;
               rvalid_s  = 1'b0;
            end
         end
         BURST: begin
            if (rvalid_r && bus.RREADY) begin
               if (rlast_r) begin
                  state_s   = IDLE;
                  beat_s    = 4'd0;
                  arready_s = 1'b1;
                  rvalid_s  = 1'b0;
                  rlast_s   = 1'b0;
                  rresp_s   = RESP_OKAY;
                  rdata_s   = 32'd0;
               end else begin
                  addr_s  = addr_adv_s;
                  beat_s  = beat_r + 4'd1;
                  rlast_s = ((beat_r + 4'd1) == len_r);
                  rdata_s = (rresp_r == RESP_OKAY) ? mem_r[adv_idx_s] : 32'd0;
               end
            end else begin
               state_s = BURST;
            end
         end
         default: begin
            state_s   = IDLE;
            beat_s    = 4'd0;
            arready_s = 1'b1;
            rvalid_s  = 1'b0;
            rlast_s   = 1'b0;
            rresp_s   = RESP_OKAY;
            rdata_s   = 32'd0;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge G_clk) begin
      if (G_reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Burst context and registered R-channel outputs; reset drops any burst in flight.
   always_ff @(posedge G_clk) begin
      if (G_reset) begin
         addr_r    <= 32'd0;
         len_r     <= 4'd0;
         size_r    <= 3'd0;
         burst_r   <= 2'd0;
         beat_r    <= 4'd0;
         arready_r <= 1'b1;
         rvalid_r  <= 1'b0;
         rlast_r   <= 1'b0;
         rresp_r   <= RESP_OKAY;
         rdata_r   <= 32'd0;
      end else begin
         addr_r    <= addr_s;
         len_r     <= len_s;
         size_r    <= size_s;
         burst_r   <= burst_s;
         beat_r    <= beat_s;
         arready_r <= arready_s;
         rvalid_r  <= rvalid_s;
         rlast_r   <= rlast_s;
         rresp_r   <= rresp_s;
         rdata_r   <= rdata_s;
      end
   end

   // Backdoor preload port; contents survive reset, and a same-edge read sees the old word.
   always_ff @(posedge G_clk) begin
      if (mem_we) begin
         mem_r[mem_waddr] <= mem_wdata;
      end
   end

   assign bus.ARREADY = arready_r;
   assign bus.RVALID  = rvalid_r;
   assign bus.RLAST   = rlast_r;
   assign bus.RRESP   = rresp_r;
   assign bus.RDATA   = rdata_r;

endmodule

// File: tb/tb_axi_read_slave.sv
// Testbench for axi_read_slave: a table of bursts checked beat by beat through a
// scoreboard queue, plus hand-written reset, back-to-back and collision sequences.
module tb_axi_read_slave;

   logic       clk;
   logic       G_reset;
   logic [31:0] slave_addr1;
   logic [31:0] slave_addr2;
   logic       mem_we;
   logic [5:0] mem_waddr;
   logic [31:0] mem_wdata;

   axi_read_slave_if bus ();

   axi_read_slave #(.DEPTH(64)) dut (
      .G_clk       (clk),
      .G_reset     (G_reset),
      .slave_addr1 (slave_addr1),
      .slave_addr2 (slave_addr2),
      .bus         (bus.slave),
      .mem_we      (mem_we),
      .mem_waddr   (mem_waddr),
      .mem_wdata   (mem_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0]      data;
      logic [1:0]       resp;
      logic             last;
   } beat_t;

   typedef struct packed {
      logic [31:0]      addr;
      logic [3:0]       len;
      logic [2:0]       size;
      logic [1:0]       burst;
      logic [7:0]       stall_beat;
      logic [7:0]       stall_cyc;
      logic [1:0]       resp;
      logic [3:0][31:0] d;
   } vec_t;

   beat_t sb[$];
   vec_t  vt [10];
   int    n_vec = 0;
   int    n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] addr, input logic [3:0] len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input logic [7:0] sbeat, input logic [7:0] scyc,
                               input logic [1:0] resp,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3);
      vec_t v;
      v.addr = addr; v.len = len; v.size = size; v.burst = burst;
      v.stall_beat = sbeat; v.stall_cyc = scyc; v.resp = resp;
      v.d = {d3, d2, d1, d0};
      return v;
   endfunction

   // Called at a negedge; returns at the negedge after the address was accepted.
   task automatic send_ar(input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input string tag);
      int guard = 0;
      bus.ARADDR  = addr;
      bus.ARLEN   = len;
      bus.ARSIZE  = size;
      bus.ARBURST = burst;
      bus.ARVALID = 1'b1;
      while (!bus.ARREADY && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk({tag, " arready_timeout"}, 32'(guard < 50), 32'd1);
      @(negedge clk);
      bus.ARVALID = 1'b0;
      chk({tag, " arready_low_in_burst"}, 32'(bus.ARREADY), 32'd0);
   endtask

   // Drains the scoreboard, optionally stalling RREADY on one beat.
   task automatic collect(input int stall_beat, input int stall_cyc, input string tag);
      int    beat = 0;
      int    stalled = 0;
      int    guard = 0;
      beat_t e;
      while (sb.size() > 0 && guard < 200) begin
         guard++;
         if (beat == stall_beat && stalled < stall_cyc) begin
            bus.RREADY = 1'b0;
            stalled++;
            chk({tag, " stall_rvalid"}, 32'(bus.RVALID), 32'd1);
            chk({tag, " stall_rdata"}, bus.RDATA, sb[0].data);
            chk({tag, " stall_rlast"}, 32'(bus.RLAST), 32'(sb[0].last));
         end else begin
            bus.RREADY = 1'b1;
            if (bus.RVALID) begin
               e = sb.pop_front();
               chk($sformatf("%s beat%0d_rdata", tag, beat), bus.RDATA, e.data);
               chk($sformatf("%s beat%0d_rresp", tag, beat), 32'(bus.RRESP), 32'(e.resp));
               chk($sformatf("%s beat%0d_rlast", tag, beat), 32'(bus.RLAST), 32'(e.last));
               beat++;
            end
         end
         @(negedge clk);
      end
      chk({tag, " beats_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
      bus.RREADY = 1'b0;
      chk({tag, " rvalid_after_last"}, 32'(bus.RVALID), 32'd0);
      chk({tag, " arready_after_last"}, 32'(bus.ARREADY), 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      beat_t b;
      for (int i = 0; i <= int'(v.len); i++) begin
         b.data = v.d[i];
         b.resp = v.resp;
         b.last = (i == int'(v.len));
         sb.push_back(b);
      end
      send_ar(v.addr, v.len, v.size, v.burst, tag);
      collect(int'(v.stall_beat), int'(v.stall_cyc), tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vt[0] = mk(32'h1010, 4'd3, 3'd2, 2'b01, 8'd1, 8'd3, 2'b00,
                 32'hA0000004, 32'hA0000005, 32'hA0000006, 32'hA0000007);
      vt[1] = mk(32'h1008, 4'd3, 3'd2, 2'b10, 8'd99, 8'd0, 2'b00,
                 32'hA0000002, 32'hA0000003, 32'hA0000000, 32'hA0000001);
      vt[2] = mk(32'h1004, 4'd2, 3'd2, 2'b00, 8'd99, 8'd0, 2'b00,
                 32'hA0000001, 32'hA0000001, 32'hA0000001, 32'h0);
      vt[3] = mk(32'h2000, 4'd1, 3'd2, 2'b01, 8'd0, 8'd2, 2'b11,
                 32'h0, 32'h0, 32'h0, 32'h0);
      vt[4] = mk(32'h1000, 4'd0, 3'd3, 2'b01, 8'd99, 8'd0, 2'b10,
                 32'h0, 32'h0, 32'h0, 32'h0);
      vt[5] = mk(32'h1000, 4'd2, 3'd2, 2'b10, 8'd99, 8'd0, 2'b10,
                 32'h0, 32'h0, 32'h0, 32'h0);
      vt[6] = mk(32'h10F8, 4'd3, 3'd2, 2'b01, 8'd99, 8'd0, 2'b00,
                 32'hA000003E, 32'hA000003F, 32'hA0000000, 32'hA0000001);
      vt[7] = mk(32'h0FFC, 4'd0, 3'd2, 2'b01, 8'd99, 8'd0, 2'b11,
                 32'h0, 32'h0, 32'h0, 32'h0);
      vt[8] = mk(32'h10FF, 4'd0, 3'd0, 2'b01, 8'd99, 8'd0, 2'b00,
                 32'hA000003F, 32'h0, 32'h0, 32'h0);
      vt[9] = mk(32'h1002, 4'd3, 3'd1, 2'b01, 8'd99, 8'd0, 2'b00,
                 32'hA0000000, 32'hA0000001, 32'hA0000001, 32'hA0000002);

      slave_addr1 = 32'h1000;
      slave_addr2 = 32'h10FF;
      G_reset     = 1'b1;
      mem_we      = 1'b0;
      mem_waddr   = 6'd0;
      mem_wdata   = 32'd0;
      bus.ARADDR  = 32'd0;
      bus.ARLEN   = 4'd0;
      bus.ARSIZE  = 3'd0;
      bus.ARBURST = 2'd0;
      bus.ARVALID = 1'b0;
      bus.RREADY  = 1'b0;

      // Preload memory while reset is held.
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         mem_we    = 1'b1;
         mem_waddr = 6'(i);
         mem_wdata = 32'hA0000000 + 32'(i);
      end
      @(negedge clk);
      mem_we = 1'b0;
      chk("reset arready", 32'(bus.ARREADY), 32'd1);
      chk("reset rvalid", 32'(bus.RVALID), 32'd0);
      chk("reset rlast", 32'(bus.RLAST), 32'd0);
      chk("reset rresp", 32'(bus.RRESP), 32'd0);
      chk("reset rdata", bus.RDATA, 32'd0);
      G_reset = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 10; k++) begin
         run_vec(vt[k], $sformatf("vec%0d", k));
         @(negedge clk);
      end

      // Back-to-back: second address held during a burst.
      bus.ARADDR = 32'h1000; bus.ARLEN = 4'd1; bus.ARSIZE = 3'd2; bus.ARBURST = 2'b01;
      bus.ARVALID = 1'b1;
      @(negedge clk);
      bus.ARADDR = 32'h1020; bus.ARLEN = 4'd0;
      bus.RREADY = 1'b1;
      chk("b2b arready_beat0", 32'(bus.ARREADY), 32'd0);
      chk("b2b rdata_beat0", bus.RDATA, 32'hA0000000);
      @(negedge clk);
      chk("b2b arready_beat1", 32'(bus.ARREADY), 32'd0);
      chk("b2b rdata_beat1", bus.RDATA, 32'hA0000001);
      chk("b2b rlast_beat1", 32'(bus.RLAST), 32'd1);
      @(negedge clk);
      chk("b2b rvalid_gap", 32'(bus.RVALID), 32'd0);
      chk("b2b arready_gap", 32'(bus.ARREADY), 32'd1);
      @(negedge clk);
      bus.ARVALID = 1'b0;
      chk("b2b second_rvalid", 32'(bus.RVALID), 32'd1);
      chk("b2b second_rdata", bus.RDATA, 32'hA0000008);
      chk("b2b second_rlast", 32'(bus.RLAST), 32'd1);
      @(negedge clk);
      bus.RREADY = 1'b0;
      chk("b2b idle_after", 32'(bus.RVALID), 32'd0);
      @(negedge clk);

      // Reset after beat 1 of a 4-beat burst, with ARVALID present at the reset edge.
      send_ar(32'h1000, 4'd3, 3'd2, 2'b01, "rst");
      bus.RREADY = 1'b1;
      chk("rst beat0_rdata", bus.RDATA, 32'hA0000000);
      @(negedge clk);
      chk("rst beat1_rdata", bus.RDATA, 32'hA0000001);
      G_reset = 1'b1;
      bus.ARADDR = 32'h1000; bus.ARLEN = 4'd0; bus.ARVALID = 1'b1;
      @(negedge clk);
      G_reset = 1'b0;
      bus.ARVALID = 1'b0;
      chk("rst rvalid", 32'(bus.RVALID), 32'd0);
      chk("rst arready", 32'(bus.ARREADY), 32'd1);
      chk("rst rdata", bus.RDATA, 32'd0);
      chk("rst rlast", 32'(bus.RLAST), 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("rst no_beat%0d", i), 32'(bus.RVALID), 32'd0);
      end
      bus.RREADY = 1'b0;

      // Backdoor write to index 5 on the edge that loads beat index 5.
      send_ar(32'h1010, 4'd1, 3'd2, 2'b01, "coll");
      bus.RREADY = 1'b1;
      mem_we = 1'b1; mem_waddr = 6'd5; mem_wdata = 32'hDEADBEEF;
      chk("coll beat0_rdata", bus.RDATA, 32'hA0000004);
      @(negedge clk);
      mem_we = 1'b0;
      chk("coll beat1_old_rdata", bus.RDATA, 32'hA0000005);
      chk("coll beat1_rlast", 32'(bus.RLAST), 32'd1);
      @(negedge clk);
      bus.RREADY = 1'b0;
      chk("coll rvalid_after", 32'(bus.RVALID), 32'd0);
      run_vec(mk(32'h1014, 4'd0, 3'd2, 2'b01, 8'd99, 8'd0, 2'b00,
                 32'hDEADBEEF, 32'h0, 32'h0, 32'h0), "coll_reread");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
